// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths and opcodes for the ALU, its result FIFO and benches
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-around pointer register with increment enable and flush
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   clr  - synchronous flush to zero, wins over inc
//   inc  - advance pointer by one this cycle
//   ptr  - current pointer value, wraps naturally at 2**W
module fifo_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - first-word-fall-through FIFO buffering ALU result words
//
// Ports:
//   clk, rst (async active-low), clr (sync flush)
//   in_data/in_valid/in_ready     - write side, valid/ready
//   out_data/out_valid/out_ready  - read side, fall-through head word
//   count, full, empty            - occupancy and status
//   ovf                           - sticky: write attempted while full
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [DATA_W_P-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W_P-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty,
    output logic                ovf
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W_P-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                push;
    logic                pop;

    // Status comes only from registered count, so out_ready never reaches in_ready.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    fifo_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (push),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Storage is deliberately not reset; empty masks stale contents on out_data.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_W'(1);
        end else if (pop && !push) begin
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (in_valid && full) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Buffers the 8-bit registered result stream produced by the sequential ALU stage.
- A downstream consumer (display, checker or serializer) drains it at its own pace.
- Sits directly downstream of the ALU `out` port.
- Write side: valid/ready. Read side: first-word-fall-through with valid/ready, plus occupancy, status and a sticky overflow flag.

Parameters:
- DATA_W, 8, width of one ALU result word. Matches the ALU `out` width.
- DEPTH, 4, number of entries. Must be a power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count. Derived; not overridden.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- clr  in  1  synchronous flush, active-high.
- in_data  in  DATA_W  ALU result word to store.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  FIFO can accept a word this cycle.
- out_data  out  DATA_W  head-of-queue word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer takes out_data this cycle.
- count  out  CNT_W  number of stored words, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - wr_ptr=0, rd_ptr=0, count=0, ovf=0.
  - Outputs: empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents; release is synchronous to the next rising edge.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Status outputs:
  - in_ready = ~full. It depends only on registered state, so there is no combinational path from out_ready to in_ready.
  - out_valid = ~empty.
  - out_data = mem[rd_ptr] when ~empty, else 0. This is combinational from registered state (fall-through).
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N. Minimum one cycle from in to out; there is no same-cycle bypass.
- Push: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
- Pop: rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop together.
- Simultaneous cases:
  - Push and pop in the same cycle with 0 < count < DEPTH: both occur and count holds.
  - When full, push is blocked (in_ready=0); a pop that cycle still occurs, and in_ready rises the next cycle.
  - When empty, pop is impossible (out_valid=0); a push that cycle lands normally.
- Overflow:
  - in_valid=1 while full sets ovf=1 at the edge. The word is dropped and storage is unchanged.
  - ovf holds until reset or clr.
- clr=1:
  - At the edge, pointers and count go to 0 and ovf goes to 0.
  - clr overrides any push/pop that cycle; no write occurs.
- Pointer width: log2(DEPTH) bits with natural wrap. count is kept separately, so full and empty are unambiguous.
- No X on any output after reset. in_data is ignored when in_valid=0.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W (8) and the ALU opcode width (2).
  - The ALU opcode constants, so ALU, FIFO and benches agree.
- No sub-module needed. Storage, pointers and count live in one module.
- An optional sub-module fifo_ptr (a wrap-around pointer register with increment enable) is acceptable if reused for both pointers.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0, ovf=0.
- Fill and drain: push 0x05, 0x0C, 0x21, 0x06 with out_ready=0, then set out_ready=1 for 4 cycles.
  - During the push: count goes 1,2,3,4 and full=1 after the 4th.
  - During the drain: out_data sequence is 0x05, 0x0C, 0x21, 0x06, and empty=1 at the end.
- Overflow: with full and 0x05..0x06 stored, drive in_valid=1, in_data=0xFF for 1 cycle.
  - ovf=1, count stays 4, and the drain yields no 0xFF.
  - clr=1 for one cycle → count=0, ovf=0.
- Concurrency:
  - At count=2 with in_valid=1 and out_ready=1 for 6 cycles of random data: count stays 2 and output order equals input order.
  - At full, pop one while in_valid=1: nothing is accepted that cycle, and in_ready=1 the next cycle.
- Wrap-around: run 10 push/pop pairs so the pointers pass DEPTH twice → order preserved and no spurious full/empty.
- Async reset mid-stream: assert rst=0 between clock edges with count=3 → all outputs take their reset values immediately, without waiting for an edge.
